mix_engine: RTL and testbench

MIX_ENGINE -- requirements
Module: mix_engine

---
 rtl/mix_pkg.sv | 20 ++
 rtl/mix_sum_sat.sv | 24 ++
 rtl/mix_engine.sv | 210 +++++++++++++++++++++
 tb/tb_mix_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// Shared state encoding, default parameters and lane saturation for the mix engine.
package mix_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FETCH, S_SUM, S_PLAY, S_WRITE, S_WRITE_LEN, S_DONE
  } mix_state_e;

  localparam int NUM_CH_DEF  = 4;
  localparam int ADDR_W_DEF  = 23;
  localparam int SHIFT_DEF   = 2;
  localparam int REPEAT_DEF  = 2;
  localparam int REC_MAX_DEF = 1 << 22;

  function automatic logic [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)  return 16'h7fff;
    if (v < -32'sd32768) return 16'h8000;
    return v[15:0];
  endfunction

endpackage

// File: rtl/mix_sum_sat.sv
// One audio lane: widened signed sum of all channels, arithmetic shift, saturate to 16 bits.
module mix_sum_sat
  import mix_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic [NUM_CH-1:0][15:0] lane_i,
  output logic [15:0]             sat_o
);

  localparam int SW = 16 + $clog2(NUM_CH);

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;

  always_comb begin
    sum = '0;
    for (int c = 0; c < NUM_CH; c++) sum = sum + SW'(signed'(lane_i[c]));
    shifted = sum >>> SHIFT;
    sat_o   = sat16(32'(shifted));
  end

endmodule

// File: rtl/mix_engine.sv
// Multi-channel SDRAM track mixer: walks track headers, fetches one word per channel per
// sample, mixes to a held stereo output and optionally records the mix back to SDRAM.
module mix_engine
  import mix_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int SHIFT   = SHIFT_DEF,
  parameter int REPEAT  = REPEAT_DEF,
  parameter int REC_MAX = REC_MAX_DEF
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           mix_start,
  input  logic [NUM_CH-1:0]              mix_ch_en,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  mix_ch_addr,
  input  logic                           mix_rec_en,
  input  logic [ADDR_W-1:0]              mix_rec_addr,
  input  logic                           mix_stop,
  output logic                           mix_busy,
  output logic                           mix_done,
  output logic                           mix_read,
  output logic                           mix_write,
  output logic [ADDR_W-1:0]              mix_addr,
  output logic [31:0]                    mix_writedata,
  input  logic [31:0]                    mix_readdata,
  input  logic                           mix_sdram_finished,
  output logic                           mix_audio_valid,
  output logic [31:0]                    mix_audio_data,
  input  logic                           mix_audio_ready
);

  localparam int IW  = $clog2(NUM_CH + 1);
  localparam int CIW = $clog2(NUM_CH);
  localparam int CW  = $clog2(REC_MAX + 1);
  localparam int RW  = $clog2(REPEAT + 1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  mix_state_e                     state_q, state_d;
  logic [NUM_CH-1:0]              ch_en_q, ch_en_d;
  logic [NUM_CH-1:0][ADDR_W-1:0]  ptr_q, ptr_d, end_q, end_d;
  logic [NUM_CH-1:0][31:0]        samp_q, samp_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic                           rec_en_q, rec_en_d, stop_q, stop_d;
  logic [ADDR_W-1:0]              rec_base_q, rec_base_d, rec_ptr_q, rec_ptr_d;
  logic [CW-1:0]                  rec_cnt_q, rec_cnt_d;
  logic                           rd_q, rd_d, wr_q, wr_d, vld_q, vld_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [31:0]                    wdata_q, wdata_d, aud_q, aud_d;
  logic [RW-1:0]                  rep_q, rep_d;

  logic [NUM_CH-1:0]              act;
  logic [NUM_CH-1:0][15:0]        lane_l, lane_r;
  logic [15:0]                    mix_l, mix_r;
  logic [CIW-1:0]                 cur;
  logic                           last;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign lane_l[c] = samp_q[c][31:16];
    assign lane_r[c] = samp_q[c][15:0];
    assign act[c]    = ch_en_q[c] && (ptr_q[c] != end_q[c]);
  end

  mix_sum_sat #(.NUM_CH(NUM_CH), .SHIFT(SHIFT)) u_sum_l (.lane_i(lane_l), .sat_o(mix_l));
  mix_sum_sat #(.NUM_CH(NUM_CH), .SHIFT(SHIFT)) u_sum_r (.lane_i(lane_r), .sat_o(mix_r));

  assign cur  = idx_q[CIW-1:0];
  assign last = (idx_q == IW'(NUM_CH));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;   ch_en_q <= '0;   ptr_q <= '0;     end_q <= '0;
      samp_q <= '0;        idx_q <= '0;     rec_en_q <= 1'b0; stop_q <= 1'b0;
      rec_base_q <= '0;    rec_ptr_q <= '0; rec_cnt_q <= '0;
      rd_q <= 1'b0;        wr_q <= 1'b0;    vld_q <= 1'b0;
      addr_q <= '0;        wdata_q <= '0;   aud_q <= '0;      rep_q <= '0;
    end else begin
      state_q <= state_d;  ch_en_q <= ch_en_d; ptr_q <= ptr_d; end_q <= end_d;
      samp_q <= samp_d;    idx_q <= idx_d;     rec_en_q <= rec_en_d; stop_q <= stop_d;
      rec_base_q <= rec_base_d; rec_ptr_q <= rec_ptr_d; rec_cnt_q <= rec_cnt_d;
      rd_q <= rd_d;        wr_q <= wr_d;       vld_q <= vld_d;
      addr_q <= addr_d;    wdata_q <= wdata_d; aud_q <= aud_d;   rep_q <= rep_d;
    end
  end

  // Next state and datapath. Requests are only (re)issued while no request is
  // outstanding, so address/data stay stable until finished.
  always_comb begin
    state_d = state_q;   ch_en_d = ch_en_q;   ptr_d = ptr_q;     end_d = end_q;
    samp_d = samp_q;     idx_d = idx_q;       rec_en_d = rec_en_q;
    stop_d = stop_q | mix_stop;
    rec_base_d = rec_base_q; rec_ptr_d = rec_ptr_q; rec_cnt_d = rec_cnt_q;
    rd_d = rd_q;         wr_d = wr_q;         vld_d = vld_q;
    addr_d = addr_q;     wdata_d = wdata_q;   aud_d = aud_q;     rep_d = rep_q;
    unique case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (mix_start && |mix_ch_en) begin
          state_d    = S_HDR;
          ch_en_d    = mix_ch_en;
          ptr_d      = mix_ch_addr;
          end_d      = mix_ch_addr;
          idx_d      = '0;
          rec_en_d   = mix_rec_en;
          rec_base_d = mix_rec_addr;
          rec_ptr_d  = mix_rec_addr + ONE_A;
          rec_cnt_d  = '0;
        end
      end
      S_HDR: begin
        if (rd_q) begin
          if (mix_sdram_finished) begin
            rd_d       = 1'b0;
            ptr_d[cur] = ptr_q[cur] + ONE_A;
            end_d[cur] = ptr_q[cur] + ONE_A + mix_readdata[ADDR_W-1:0];
            idx_d      = idx_q + IW'(1);
          end
        end else if (last) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end else if (ch_en_q[cur]) begin
          rd_d   = 1'b1;
          addr_d = ptr_q[cur];
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_FETCH: begin
        // Entry point of every sample round: stop, exhaustion and record limit end here.
        if (idx_q == '0 && !rd_q &&
            (stop_q || act == '0 || rec_cnt_q == CW'(REC_MAX))) begin
          state_d = rec_en_q ? S_WRITE_LEN : S_DONE;
        end else if (rd_q) begin
          if (mix_sdram_finished) begin
            rd_d        = 1'b0;
            samp_d[cur] = mix_readdata;
            ptr_d[cur]  = ptr_q[cur] + ONE_A;
            idx_d       = idx_q + IW'(1);
          end
        end else if (last) begin
          state_d = S_SUM;
          idx_d   = '0;
        end else if (act[cur]) begin
          rd_d   = 1'b1;
          addr_d = ptr_q[cur];
        end else begin
          samp_d[cur] = '0;
          idx_d       = idx_q + IW'(1);
        end
      end
      S_SUM: begin
        aud_d   = {mix_l, mix_r};
        vld_d   = 1'b1;
        rep_d   = '0;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (mix_audio_ready) begin
          if (rep_q == RW'(REPEAT - 1)) begin
            vld_d   = 1'b0;
            state_d = S_WRITE;
          end else begin
            rep_d = rep_q + RW'(1);
          end
        end
      end
      S_WRITE: begin
        if (!rec_en_q) begin
          state_d = S_FETCH;
        end else if (!wr_q) begin
          wr_d    = 1'b1;
          addr_d  = rec_ptr_q;
          wdata_d = aud_q;
        end else if (mix_sdram_finished) begin
          wr_d      = 1'b0;
          rec_ptr_d = rec_ptr_q + ONE_A;
          rec_cnt_d = rec_cnt_q + CW'(1);
          state_d   = S_FETCH;
        end
      end
      S_WRITE_LEN: begin
        if (!wr_q) begin
          wr_d    = 1'b1;
          addr_d  = rec_base_q;
          wdata_d = 32'(rec_cnt_q);
        end else if (mix_sdram_finished) begin
          wr_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        stop_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mix_busy        = (state_q != S_IDLE);
    mix_done        = (state_q == S_DONE);
    mix_read        = rd_q;
    mix_write       = wr_q;
    mix_addr        = addr_q;
    mix_writedata   = wdata_q;
    mix_audio_valid = vld_q;
    mix_audio_data  = aud_q;
  end

endmodule

// File: tb/tb_mix_engine.sv
// Directed bench for mix_engine: SDRAM model, audio sink, two instances differing only in SHIFT.
module tb_mix_engine;

  localparam int NCH = 4;
  localparam int AW  = 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, start, rec_en, stop_p, ready;
  logic [NCH-1:0]          ch_en;
  logic [NCH-1:0][AW-1:0]  ch_addr;
  logic [AW-1:0]           rec_addr;
  logic                    sd_fin = 1'b0;
  logic [31:0]             sd_rdata = '0;

  logic a_busy, a_done, a_rd, a_wr, a_vld;
  logic [AW-1:0] a_addr;
  logic [31:0] a_wdata, a_aud;
  logic b_busy, b_done, b_rd, b_wr, b_vld;
  logic [AW-1:0] b_addr;
  logic [31:0] b_wdata, b_aud;

  mix_engine #(.NUM_CH(NCH), .ADDR_W(AW), .SHIFT(2), .REPEAT(2), .REC_MAX(1 << 22)) dut (
    .i_clk(clk), .i_rst(rst), .mix_start(start), .mix_ch_en(ch_en), .mix_ch_addr(ch_addr),
    .mix_rec_en(rec_en), .mix_rec_addr(rec_addr), .mix_stop(stop_p),
    .mix_busy(a_busy), .mix_done(a_done), .mix_read(a_rd), .mix_write(a_wr),
    .mix_addr(a_addr), .mix_writedata(a_wdata), .mix_readdata(sd_rdata),
    .mix_sdram_finished(sd_fin), .mix_audio_valid(a_vld), .mix_audio_data(a_aud),
    .mix_audio_ready(ready));

  // Unshifted twin: identical control timing, so it shares the SDRAM responses.
  mix_engine #(.NUM_CH(NCH), .ADDR_W(AW), .SHIFT(0), .REPEAT(2), .REC_MAX(1 << 22)) dut_b (
    .i_clk(clk), .i_rst(rst), .mix_start(start), .mix_ch_en(ch_en), .mix_ch_addr(ch_addr),
    .mix_rec_en(rec_en), .mix_rec_addr(rec_addr), .mix_stop(stop_p),
    .mix_busy(b_busy), .mix_done(b_done), .mix_read(b_rd), .mix_write(b_wr),
    .mix_addr(b_addr), .mix_writedata(b_wdata), .mix_readdata(sd_rdata),
    .mix_sdram_finished(sd_fin), .mix_audio_valid(b_vld), .mix_audio_data(b_aud),
    .mix_audio_ready(ready));

  // SDRAM: three cycles per transaction, stallable, one-cycle finished strobe.
  logic [31:0]   mem [0:1023];
  logic          stall;
  int            cnt = 0;
  int            rd_cnt = 0;
  logic [AW-1:0] wlog_a [$];
  logic [31:0]   wlog_d [$];

  always @(posedge clk) begin
    if (rst) begin
      sd_fin <= 1'b0;
      cnt    <= 0;
    end else if (sd_fin) begin
      sd_fin <= 1'b0;
    end else if ((a_rd || a_wr) && !stall) begin
      if (cnt == 2) begin
        cnt    <= 0;
        sd_fin <= 1'b1;
        if (a_rd) begin
          sd_rdata <= mem[a_addr[9:0]];
          rd_cnt = rd_cnt + 1;
        end else begin
          mem[a_addr[9:0]] = a_wdata;
          wlog_a.push_back(a_addr);
          wlog_d.push_back(a_wdata);
        end
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  logic [31:0]   hs_a [$];
  logic [31:0]   hs_b [$];
  int            done_cnt = 0;
  logic          rw_err = 1'b0, stab_err = 1'b0, hold_err = 1'b0, lock_err = 1'b0;
  logic          p_rd = 1'b0, p_wr = 1'b0, p_vld = 1'b0, p_rdy = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [31:0]   p_wd = '0, p_aud = '0;

  always @(posedge clk) begin
    if (a_vld && ready) begin
      hs_a.push_back(a_aud);
      hs_b.push_back(b_aud);
    end
    if (a_done) done_cnt++;
    if (a_rd && a_wr) rw_err = 1'b1;
    if (((a_rd && p_rd) || (a_wr && p_wr)) && (a_addr !== p_addr || (a_wr && a_wdata !== p_wd)))
      stab_err = 1'b1;
    if (p_vld && !p_rdy && a_vld && a_aud !== p_aud) hold_err = 1'b1;
    if ({b_busy, b_done, b_rd, b_wr, b_vld, b_addr} !== {a_busy, a_done, a_rd, a_wr, a_vld, a_addr})
      lock_err = 1'b1;
    p_rd = a_rd; p_wr = a_wr; p_vld = a_vld; p_rdy = ready;
    p_addr = a_addr; p_wd = a_wdata; p_aud = a_aud;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [NCH-1:0] en, input logic r, input logic [AW-1:0] ra);
    @(negedge clk);
    ch_en = en; rec_en = r; rec_addr = ra; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int s, n;
    s = done_cnt; n = 0;
    while (done_cnt == s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done_cnt - s), 32'd1);
  endtask

  task automatic wait_rd(input string tag, input logic [AW-1:0] ad, input int budget);
    int n;
    n = 0;
    while (!(a_rd && a_addr == ad) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(a_rd && a_addr == ad), 32'd1);
  endtask

  initial begin
    int hb, rb, wb;
    logic held;
    rst = 1'b1; start = 1'b0; rec_en = 1'b0; stop_p = 1'b0; ready = 1'b1; stall = 1'b0;
    ch_en = '0; ch_addr = '0; rec_addr = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    // s1 tracks
    mem[10'h010] = 32'd3;
    for (int i = 1; i <= 3; i++) mem[10'h010 + i] = 32'h1000_1000;
    mem[10'h020] = 32'd5;
    for (int i = 1; i <= 5; i++) mem[10'h020 + i] = 32'h1000_1000;
    // s2 tracks: full-scale positive, full-scale negative, mixed sign
    for (int c = 0; c < 4; c++) begin
      mem[10'h040 + 16 * c]     = 32'd3;
      mem[10'h040 + 16 * c + 1] = 32'h7fff_7fff;
      mem[10'h040 + 16 * c + 2] = 32'h8000_8000;
      mem[10'h040 + 16 * c + 3] = (c == 0) ? 32'h0001_0004 : 32'hffff_0000;
    end
    // s3, s4, s5 tracks
    mem[10'h080] = 32'd3;
    mem[10'h081] = 32'h0004_0008; mem[10'h082] = 32'h0010_0020; mem[10'h083] = 32'hfffc_fff8;
    mem[10'h0c0] = 32'd4;
    for (int i = 1; i <= 4; i++) mem[10'h0c0 + i] = 32'h0004_0004;
    mem[10'h0e0] = 32'd1;
    mem[10'h0e1] = 32'h0100_0200;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_read", 32'(a_rd), 32'd0);
    chk("rst_write", 32'(a_wr), 32'd0);
    chk("rst_valid", 32'(a_vld), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    rst = 1'b0;

    // s1: lengths 3 and 5
    hb = hs_a.size();
    ch_addr[0] = 23'h010; ch_addr[1] = 23'h020;
    go(4'b0011, 1'b0, '0);
    chk("s1_busy", 32'(a_busy), 32'd1);
    wait_done("s1_done", 2000);
    chk("s1_count", 32'(hs_a.size() - hb), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("s1_hs%0d", i), hs_a[hb + i], (i < 6) ? 32'h0800_0800 : 32'h0400_0400);
    @(negedge clk);
    chk("s1_idle", 32'(a_busy), 32'd0);

    // s2: four channels, saturation on the unshifted twin
    hb = hs_a.size();
    ch_addr[0] = 23'h040; ch_addr[1] = 23'h050; ch_addr[2] = 23'h060; ch_addr[3] = 23'h070;
    go(4'b1111, 1'b0, '0);
    wait_done("s2_done", 3000);
    chk("s2_count", 32'(hs_a.size() - hb), 32'd6);
    chk("s2_pos_shift", hs_a[hb + 0], 32'h7fff_7fff);
    chk("s2_pos_sat",   hs_b[hb + 1], 32'h7fff_7fff);
    chk("s2_neg_shift", hs_a[hb + 2], 32'h8000_8000);
    chk("s2_neg_sat",   hs_b[hb + 3], 32'h8000_8000);
    chk("s2_mix_shift", hs_a[hb + 4], 32'hffff_0001);
    chk("s2_mix_raw",   hs_b[hb + 5], 32'hfffe_0004);

    // s3: record a 3-sample track to 0x100
    hb = hs_a.size(); wb = wlog_a.size();
    ch_addr[0] = 23'h080;
    go(4'b0001, 1'b1, 23'h100);
    wait_done("s3_done", 2000);
    chk("s3_hs_count", 32'(hs_a.size() - hb), 32'd6);
    chk("s3_wr_count", 32'(wlog_a.size() - wb), 32'd4);
    chk("s3_w0_addr", 32'(wlog_a[wb + 0]), 32'h101);
    chk("s3_w0_data", wlog_d[wb + 0], 32'h0001_0002);
    chk("s3_w1_addr", 32'(wlog_a[wb + 1]), 32'h102);
    chk("s3_w1_data", wlog_d[wb + 1], 32'h0004_0008);
    chk("s3_w2_addr", 32'(wlog_a[wb + 2]), 32'h103);
    chk("s3_w2_data", wlog_d[wb + 2], 32'hffff_fffe);
    chk("s3_len_addr", 32'(wlog_a[wb + 3]), 32'h100);
    chk("s3_len_data", wlog_d[wb + 3], 32'd3);

    // s4: stop while the first sample read is held
    hb = hs_a.size(); wb = wlog_a.size(); rb = rd_cnt;
    ch_addr[0] = 23'h0c0;
    go(4'b0001, 1'b1, 23'h140);
    wait_rd("s4_wait_rd", 23'h0c1, 200);
    stall = 1'b1;
    stop_p = 1'b1;
    @(negedge clk);
    stop_p = 1'b0;
    repeat (4) @(negedge clk);
    chk("s4_rd_held", 32'(a_rd), 32'd1);
    stall = 1'b0;
    wait_done("s4_done", 2000);
    chk("s4_reads", 32'(rd_cnt - rb), 32'd2);
    chk("s4_hs_count", 32'(hs_a.size() - hb), 32'd2);
    chk("s4_hs0", hs_a[hb], 32'h0001_0001);
    chk("s4_wr_count", 32'(wlog_a.size() - wb), 32'd2);
    chk("s4_w0_addr", 32'(wlog_a[wb + 0]), 32'h141);
    chk("s4_len_addr", 32'(wlog_a[wb + 1]), 32'h140);
    chk("s4_len_data", wlog_d[wb + 1], 32'd1);

    // s5: sink stalls for 10 cycles in PLAY
    hb = hs_a.size();
    ch_addr[1] = 23'h0e0;
    ready = 1'b0;
    go(4'b0010, 1'b0, '0);
    for (int n = 0; n < 200 && !a_vld; n++) @(negedge clk);
    held = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (!a_vld || a_aud !== 32'h0040_0080) held = 1'b0;
      @(negedge clk);
    end
    chk("s5_held", 32'(held), 32'd1);
    chk("s5_no_hs", 32'(hs_a.size() - hb), 32'd0);
    ready = 1'b1;
    wait_done("s5_done", 500);
    chk("s5_hs_count", 32'(hs_a.size() - hb), 32'd2);
    chk("s5_hs1", hs_a[hb + 1], 32'h0040_0080);

    // s6: reset in the middle of a header read, then a clean session
    stall = 1'b1;
    ch_addr[0] = 23'h010;
    go(4'b0001, 1'b0, '0);
    wait_rd("s6_wait_rd", 23'h010, 200);
    rst = 1'b1;
    @(negedge clk);
    chk("s6_rst_read", 32'(a_rd), 32'd0);
    chk("s6_rst_busy", 32'(a_busy), 32'd0);
    rst = 1'b0; stall = 1'b0;
    hb = hs_a.size();
    go(4'b0001, 1'b0, '0);
    wait_done("s6_done", 2000);
    chk("s6_hs_count", 32'(hs_a.size() - hb), 32'd6);
    chk("s6_hs0", hs_a[hb], 32'h0400_0400);
    chk("s6_hs5", hs_a[hb + 5], 32'h0400_0400);

    // zero enable mask is ignored
    go(4'b0000, 1'b0, '0);
    chk("zero_mask_busy", 32'(a_busy), 32'd0);

    chk("rd_wr_exclusive", 32'(rw_err), 32'd0);
    chk("req_stable", 32'(stab_err), 32'd0);
    chk("audio_hold", 32'(hold_err), 32'd0);
    chk("twin_lockstep", 32'(lock_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
